buffer_stream_ctrl: RTL

Pointer/occupancy controller that sits around the parallel-port `Buffer` memory and drives its `wen`, `waddr` and `raddr`. It accepts `PAR_WRITE`-wide words from the upstream producer and presents `PAR_READ`-wide sliding windows to the downstream consumer. Both sides use valid/ready handshakes. The read window advances by `READ_STRIDE` entries per consumed window, and frames are delimited by `in_last`.

---
 rtl/buffer_pkg.sv | 21 ++
 rtl/buffer_stream_ctrl_if.sv | 27 ++
 rtl/buffer_stream_ctrl_ring_ptr.sv | 29 ++
 rtl/buffer_stream_ctrl.sv | 88 ++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// Shared types and helpers for the buffer stream controller: FSM encoding,
// modular pointer arithmetic and the occupancy-counter width.
package buffer_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Modular add by compare-subtract, so non-power-of-two sizes wrap correctly.
    function automatic int unsigned ptr_add(int unsigned ptr, int unsigned inc, int unsigned mod);
        int unsigned sum;
        sum = ptr + inc;
        return (sum >= mod) ? sum - mod : sum;
    endfunction

    function automatic int count_width(int mem_size);
        return $clog2(mem_size + 1);
    endfunction

endpackage

// File: rtl/buffer_stream_ctrl_if.sv
// Producer/consumer handshakes plus the Buffer address/enable bus.
// The controller drives through master; the environment uses slave.
interface buffer_stream_ctrl_if #(
    parameter int ADDRES_SIZE = 2,
    parameter int COUNT_W     = 3
);
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic                   frame_done;
    logic                   wen;
    logic [ADDRES_SIZE-1:0] waddr;
    logic [ADDRES_SIZE-1:0] raddr;
    logic [COUNT_W-1:0]     count;

    modport master (
        input  in_valid, in_last, out_ready,
        output in_ready, out_valid, frame_done, wen, waddr, raddr, count
    );

    modport slave (
        output in_valid, in_last, out_ready,
        input  in_ready, out_valid, frame_done, wen, waddr, raddr, count
    );
endinterface

// File: rtl/buffer_stream_ctrl_ring_ptr.sv
// Ring pointer modulo MOD, advancing by INC; load takes priority over advance.
module ring_ptr
    import buffer_pkg::*;
#(
    parameter int MOD = 4,
    parameter int INC = 1,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (adv) begin
            ptr <= W'(ptr_add(32'(ptr), INC, MOD));
        end
    end

endmodule

// File: rtl/buffer_stream_ctrl.sv
// Pointer/occupancy controller for the external Buffer memory: accepts
// PAR_WRITE-wide words, presents PAR_READ-wide windows advancing by READ_STRIDE.
module buffer_stream_ctrl
    import buffer_pkg::*;
#(
    parameter int MEM_SIZE    = 4,
    parameter int PAR_WRITE   = 2,
    parameter int PAR_READ    = 3,
    parameter int READ_STRIDE = 1,
    parameter int ADDRES_SIZE = $clog2(MEM_SIZE)
) (
    input logic                  clk,
    input logic                  rst,
    buffer_stream_ctrl_if.master bus
);

    localparam int CW = count_width(MEM_SIZE);

    localparam logic [0:0]    S_FILL   = FILL;
    localparam logic [0:0]    S_DRAIN  = DRAIN;
    localparam logic [CW-1:0] FREE_MAX = CW'(MEM_SIZE - PAR_WRITE);
    localparam logic [CW-1:0] RD_MIN   = CW'(PAR_READ);
    localparam logic [CW-1:0] PW_C     = CW'(PAR_WRITE);
    localparam logic [CW-1:0] RS_C     = CW'(READ_STRIDE);

    logic [0:0]             state;
    logic [CW-1:0]          count;
    logic [ADDRES_SIZE-1:0] wptr;
    logic [ADDRES_SIZE-1:0] rptr;
    logic                   in_ready;
    logic                   out_valid;
    logic                   push;
    logic                   pop;
    logic                   flush;

    // in_ready comes from registered state only, keeping out_ready off this path.
    assign in_ready  = (state == S_FILL) && (count <= FREE_MAX);
    assign out_valid = (count >= RD_MIN);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;
    assign flush     = (state == S_DRAIN) && (count < RD_MIN) && !pop;

    ring_ptr #(.MOD(MEM_SIZE), .INC(PAR_WRITE), .W(ADDRES_SIZE)) u_wptr (
        .clk      (clk),
        .rst      (rst),
        .adv      (push),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (wptr)
    );

    // The drain flush discards leftover entries by snapping rptr onto wptr.
    ring_ptr #(.MOD(MEM_SIZE), .INC(READ_STRIDE), .W(ADDRES_SIZE)) u_rptr (
        .clk      (clk),
        .rst      (rst),
        .adv      (pop),
        .load     (flush),
        .load_val (wptr),
        .ptr      (rptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_FILL;
            count          <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= flush;
            if (flush) begin
                state <= S_FILL;
                count <= '0;
            end else begin
                count <= count + (push ? PW_C : '0) - (pop ? RS_C : '0);
                if (push && bus.in_last) begin
                    state <= S_DRAIN;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.wen       = push;
    assign bus.waddr     = wptr;
    assign bus.raddr     = rptr;
    assign bus.count     = count;

endmodule
